axi4lite_lsu_master: RTL and testbench
======================================

# axi4lite_lsu_master

Bridges the core's load/store unit to the AXI4-lite memory/UART slave. Accepts one word request at a time over a valid/ready request port and drives the matching AXI4-lite read or write transaction. Returns read data and the response status on a valid/ready response port. Sits directly upstream of the AXI4-lite slave; one outstanding transaction, no reordering.

## Interface
- No parameters; address and data are fixed at 32 bits, and wstrb is fixed at 8 bits to match the slave.
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when high together with req_valid
- req_wen  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_wmask  in  4  store byte enables
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  32  load data; 0 for stores
- rsp_err  out  1  captured rresp/bresp != 2'b00
- awvalid/awready/awaddr  out/in/out  1/1/32  write address channel
- wvalid/wready/wdata/wstrb  out/in/out/out  1/1/32/8  write data channel; wstrb = {4'b0, req_wmask}
- bvalid/bready/bresp  in/out/in  1/1/2  write response channel
- arvalid/arready/araddr  out/in/out  1/1/32  read address channel
- rvalid/rready/rdata/rresp  in/out/in/in  1/1/32/2  read data channel

## Operation
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch the request and go to RD_ADDR (load) or WR_REQ (store).
  - RD_ADDR: arvalid=1. On arready, go to RD_DATA.
  - RD_DATA: rready=1. On rvalid, capture rdata and rresp, then go to RSP.
  - WR_REQ: awvalid and wvalid are both asserted on entry. Each drops independently after its own handshake, tracked by the aw_done and w_done flags. When both are done, go to WR_RESP.
  - WR_RESP: bready=1. On bvalid, capture bresp, then go to RSP.
  - RSP: rsp_valid=1. On rsp_ready, go to IDLE.
- Stability:
  - awaddr, wdata, wstrb and araddr are registered copies of the latched request.
  - They are stable while the matching valid is high.
  - All four are 0 in IDLE.
- rvalid and bvalid are ignored outside RD_DATA and WR_RESP, respectively. The slave asserts them early, combinationally.
- On a store, rsp_rdata is 0. rsp_err is 1 for SLVERR (2'b10) and for DECERR (2'b11).
- rsp_err and rsp_rdata hold until the rsp handshake completes.

## Timing
- Reset values, while aresetn is low:
  - All AXI valids, bready, rready, rsp_valid and req_ready are 0.
  - All data/address outputs are 0.
  - State is IDLE.
- Reset asserted mid-transaction: all outputs drop asynchronously, the transaction is abandoned and no response is issued.
- Request accepted at cycle 0. arvalid (or awvalid+wvalid) goes high at cycle 1.
- Minimum load latency: arready at cycle 1 and rvalid at cycle 2 give rsp_valid at cycle 3.
- Minimum store latency: aw and w handshakes at cycle 1 (same cycle → straight to WR_RESP), bvalid at cycle 2, rsp_valid at cycle 3.
- Split aw/w handshakes: if aw completes at cycle n and w at cycle m, WR_RESP is entered at cycle max(n,m)+1.
- Back-to-back requests: req_ready returns the cycle after the rsp handshake, so the minimum request spacing is 4 cycles.
- A valid is never deasserted before its ready is seen.

## Structure
- Shared package axi4lite_pkg holds:
  - resp codes: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11
  - the FSM state encoding (6 states)
- Single module; no sub-module needed.

## Test plan
- Load 0x80000004: arready at cycle 1, rvalid at cycle 2 with rdata 0xDEADBEEF and rresp 00 → rsp_valid at cycle 3 with rsp_rdata 0xDEADBEEF and rsp_err 0.
- Store 0x80000010, data 0x12345678, wmask 4'b0011: awaddr 0x80000010, wdata 0x12345678, wstrb 8'h03. bresp 00 → rsp_err 0, rsp_rdata 0.
- Store with wready delayed 3 cycles after awready: awvalid drops after its handshake, wvalid stays high until wready, bready only afterwards, exactly one response.
- Load returning rresp 2'b10; separately, store returning bresp 2'b11 → rsp_err 1 in both cases.
- rsp_ready held low for 5 cycles: rsp_valid and rsp_rdata stay stable, req_ready stays 0, and a new request is accepted the cycle after the response is consumed.
- aresetn pulsed low during WR_REQ: awvalid and wvalid drop immediately, no rsp_valid is issued, and req_ready is 1 after reset release.

Source files
------------

// File: rtl/axi4lite_pkg.sv
// Shared AXI4-lite definitions: response codes and the LSU master FSM encoding.
package axi4lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_RSP     = 3'd5
  } lsu_state_e;

  // SLVERR and DECERR both have bit 1 set; OKAY and EXOKAY do not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/axi4lite_lsu_master.sv
// Load/store unit to AXI4-lite bridge: one outstanding word transaction at a time.
// Handshakes: a transfer happens on a rising aclk edge where valid and ready are both high.
module axi4lite_lsu_master
  import axi4lite_pkg::*;
(
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] awaddr,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] wdata,
  output logic [7:0]  wstrb,
  input  logic        bvalid,
  output logic        bready,
  input  logic [1:0]  bresp,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp
);

  lsu_state_e state;
  logic       aw_done;
  logic       w_done;
  logic       aw_hs;
  logic       w_hs;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= ST_IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      awvalid   <= 1'b0;
      awaddr    <= 32'h0;
      wvalid    <= 1'b0;
      wdata     <= 32'h0;
      wstrb     <= 8'h0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      araddr    <= 32'h0;
      rready    <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            if (req_wen) begin
              state   <= ST_WR_REQ;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              awaddr  <= req_addr;
              wdata   <= req_wdata;
              wstrb   <= {4'b0000, req_wmask};
              aw_done <= 1'b0;
              w_done  <= 1'b0;
            end else begin
              state   <= ST_RD_ADDR;
              arvalid <= 1'b1;
              araddr  <= req_addr;
            end
          end else begin
            // req_ready comes up one cycle after reset release.
            req_ready <= 1'b1;
          end
        end
        ST_RD_ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (rvalid) begin
            rready    <= 1'b0;
            rsp_rdata <= rdata;
            rsp_err   <= resp_is_err(rresp);
            rsp_valid <= 1'b1;
            state     <= ST_RSP;
          end
        end
        ST_WR_REQ: begin
          if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            bready  <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (bvalid) begin
            bready    <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= resp_is_err(bresp);
            rsp_valid <= 1'b1;
            state     <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            awaddr    <= 32'h0;
            wdata     <= 32'h0;
            wstrb     <= 8'h0;
            araddr    <= 32'h0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_lsu_master.sv
// Directed bench for axi4lite_lsu_master: vector table with per-channel slave timing, plus reset corner cases.
module tb_axi4lite_lsu_master;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wmask;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [7:0]  wstrb;
  logic [1:0]  bresp, rresp;

  always #5 aclk = ~aclk;

  axi4lite_lsu_master dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  // Slave timing fields give the first cycle (request accepted = cycle 0) at which
  // that ready/valid is raised; it stays high until its handshake.
  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          ar_c;
    int          r_c;
    int          aw_c;
    int          w_c;
    int          b_c;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          hold;
    int          exp_rsp;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs[NV];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic idle_slave();
    arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    rdata = 32'h0; rresp = 2'b00; bresp = 2'b00; rsp_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx, input bit expect_first);
    string       tag;
    int          tries, rsp_cyc, viol;
    bit          acc, done, rsp_seen, ar_d, r_d, aw_d, w_d, b_d;
    logic [31:0] cap_ar, cap_aw, cap_wd, cap_rd;
    logic [7:0]  cap_ws;
    logic        cap_err;
    logic        p_arv, p_awv, p_wv;
    logic [31:0] p_ar, p_aw, p_wd;
    logic [7:0]  p_ws;
    tag = $sformatf("v%0d", idx);
    acc = 0; tries = 0; done = 0; rsp_seen = 0; rsp_cyc = -1; viol = 0;
    ar_d = 0; r_d = 0; aw_d = 0; w_d = 0; b_d = 0;
    cap_ar = 0; cap_aw = 0; cap_wd = 0; cap_rd = 0; cap_ws = 0; cap_err = 0;
    p_arv = 0; p_awv = 0; p_wv = 0; p_ar = 0; p_aw = 0; p_wd = 0; p_ws = 0;
    while (!acc && tries < 10) begin
      @(posedge aclk); #1;
      idle_slave();
      req_valid = 1'b1; req_wen = v.wen; req_addr = v.addr;
      req_wdata = v.wdata; req_wmask = v.wmask;
      tries++;
      @(negedge aclk);
      if (req_ready) begin
        acc = 1;
        chk({tag, "_idle_outs"}, awaddr | araddr | wdata | {24'h0, wstrb}, 32'h0);
      end
    end
    chk({tag, "_accepted"}, {31'h0, acc}, 32'h1);
    if (expect_first) chk({tag, "_first_try"}, tries, 1);
    for (int k = 1; k <= 40 && !done; k++) begin
      @(posedge aclk); #1;
      req_valid = 1'b0;
      arready   = (k >= v.ar_c) && !ar_d;
      rvalid    = (k >= v.r_c) && !r_d;
      rdata     = v.rdata;
      rresp     = v.resp;
      awready   = (k >= v.aw_c) && !aw_d;
      wready    = (k >= v.w_c) && !w_d;
      bvalid    = (k >= v.b_c) && !b_d;
      bresp     = v.resp;
      rsp_ready = (v.hold == 0) || (rsp_seen && (k - rsp_cyc >= v.hold));
      @(negedge aclk);
      if (p_arv && (!arvalid || araddr !== p_ar)) viol++;
      if (p_awv && (!awvalid || awaddr !== p_aw)) viol++;
      if (p_wv && (!wvalid || wdata !== p_wd || wstrb !== p_ws)) viol++;
      if ((ar_d && arvalid) || (aw_d && awvalid) || (w_d && wvalid)) viol++;
      if (v.wen && (arvalid || rready)) viol++;
      if (!v.wen && (awvalid || wvalid || bready)) viol++;
      if (bready && !(aw_d && w_d)) viol++;
      if (rready && !ar_d) viol++;
      if (rsp_valid && req_ready) viol++;
      if (rsp_seen && !rsp_valid) viol++;
      if (rsp_seen && (rsp_rdata !== cap_rd || rsp_err !== cap_err)) viol++;
      if (arvalid && arready) begin ar_d = 1; cap_ar = araddr; end
      if (awvalid && awready) begin aw_d = 1; cap_aw = awaddr; end
      if (wvalid && wready) begin w_d = 1; cap_wd = wdata; cap_ws = wstrb; end
      if (rvalid && rready) r_d = 1;
      if (bvalid && bready) b_d = 1;
      if (rsp_valid && !rsp_seen) begin
        rsp_seen = 1; rsp_cyc = k; cap_rd = rsp_rdata; cap_err = rsp_err;
        if (v.wen ? !b_d : !r_d) viol++;
      end
      if (rsp_valid && rsp_ready) done = 1;
      p_arv = arvalid && !arready; p_ar = araddr;
      p_awv = awvalid && !awready; p_aw = awaddr;
      p_wv  = wvalid && !wready;   p_wd = wdata; p_ws = wstrb;
    end
    chk({tag, "_done"}, {31'h0, done}, 32'h1);
    chk({tag, "_rsp_cycle"}, rsp_cyc, v.exp_rsp);
    chk({tag, "_rsp_rdata"}, cap_rd, v.exp_rdata);
    chk({tag, "_rsp_err"}, {31'h0, cap_err}, {31'h0, v.exp_err});
    chk({tag, "_protocol"}, viol, 0);
    if (v.wen) begin
      chk({tag, "_awaddr"}, cap_aw, v.addr);
      chk({tag, "_wdata"}, cap_wd, v.wdata);
      chk({tag, "_wstrb"}, {24'h0, cap_ws}, {28'h0, v.wmask});
    end else begin
      chk({tag, "_araddr"}, cap_ar, v.addr);
    end
  endtask

  initial begin
    int  rsp_cnt;
    bit  rr_seen;
    //           wen   addr          wdata         mask    ar  r   aw  w   b   resp   rdata         hold rsp exp_rdata     err
    vecs[0] = '{1'b0, 32'h80000004, 32'h0,        4'h0,   1,  2,  99, 99, 99, 2'b00, 32'hDEADBEEF, 0,   3,  32'hDEADBEEF, 1'b0};
    vecs[1] = '{1'b1, 32'h80000010, 32'h12345678, 4'b0011, 99, 99, 1,  1,  2,  2'b00, 32'h0,        0,   3,  32'h0,        1'b0};
    vecs[2] = '{1'b1, 32'h80000020, 32'hA5A5A5A5, 4'b1111, 99, 99, 1,  4,  1,  2'b00, 32'h0,        0,   6,  32'h0,        1'b0};
    vecs[3] = '{1'b0, 32'h80000008, 32'h0,        4'h0,   3,  1,  99, 99, 99, 2'b10, 32'hCAFEF00D, 0,   5,  32'hCAFEF00D, 1'b1};
    vecs[4] = '{1'b1, 32'h8000000C, 32'h0BADF00D, 4'b1000, 99, 99, 2,  1,  1,  2'b11, 32'h0,        0,   4,  32'h0,        1'b1};
    vecs[5] = '{1'b0, 32'h80000000, 32'h0,        4'h0,   1,  2,  99, 99, 99, 2'b00, 32'h13579BDF, 5,   3,  32'h13579BDF, 1'b0};
    vecs[6] = '{1'b1, 32'h80000014, 32'hFFFF0000, 4'b1100, 99, 99, 3,  1,  5,  2'b01, 32'h0,        0,   6,  32'h0,        1'b0};
    vecs[7] = '{1'b0, 32'h80000018, 32'h0,        4'h0,   2,  1,  99, 99, 99, 2'b11, 32'h00000001, 0,   4,  32'h00000001, 1'b1};

    aresetn = 1'b0;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_wmask = 4'h0;
    idle_slave();
    repeat (2) @(negedge aclk);
    chk("reset_ctrl", {25'h0, req_ready, arvalid, awvalid, wvalid, bready, rready, rsp_valid}, 32'h0);
    chk("reset_addr", awaddr | araddr | wdata | {24'h0, wstrb}, 32'h0);
    chk("reset_rsp", rsp_rdata | {31'h0, rsp_err}, 32'h0);
    @(posedge aclk); #1;
    aresetn = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i, i != 0);

    // Reset while a store is waiting in WR_REQ.
    @(posedge aclk); #1;
    idle_slave();
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h80000030;
    req_wdata = 32'h55AA55AA; req_wmask = 4'hF;
    @(negedge aclk);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    @(posedge aclk); #1;
    req_valid = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    chk("rst_pre_valids", {30'h0, awvalid, wvalid}, 32'h3);
    #2 aresetn = 1'b0;
    #1;
    chk("rst_drop_ctrl", {27'h0, awvalid, wvalid, req_ready, rsp_valid, bready}, 32'h0);
    chk("rst_drop_data", awaddr | wdata | {24'h0, wstrb}, 32'h0);
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; rsp_ready = 1'b1;
    rsp_cnt = 0; rr_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge aclk);
      if (rsp_valid || awvalid || wvalid || bready) rsp_cnt++;
      if (req_ready) rr_seen = 1;
    end
    chk("rst_no_rsp", rsp_cnt, 0);
    chk("rst_req_ready_after", {31'h0, rr_seen}, 32'h1);
    idle_slave();

    run_vec(vecs[1], 8, 1'b0);
    run_vec(vecs[3], 9, 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
